// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH signed/unsigned, one digit per cycle.
// Operands and the full-width product move through valid/ready handshakes.
module booth_r4_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [EW-1:0]      a_q, a_d;
    logic [EW-1:0]      b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [CW:0]        shamt;
    logic [EW:0]        bx;
    logic [2:0]         digit;
    logic [AW-1:0]      a_sx;
    logic [AW-1:0]      mag;
    logic               neg;
    logic [AW-1:0]      term_sh;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      acc_sum;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign busy      = (state_q == S_RUN);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign accept    = in_valid && in_ready;

    // Digit i reads {b[2i+1], b[2i], b[2i-1]}; the appended zero supplies b[-1].
    assign shamt = {cnt_q, 1'b0};
    assign bx    = {b_q, 1'b0};
    assign digit = bx[shamt +: 3];
    assign a_sx  = {{(AW - EW){a_q[EW-1]}}, a_q};

    always_comb begin
        mag = '0;
        neg = 1'b0;
        case (digit)
            3'b001, 3'b010: mag = a_sx;
            3'b011:         mag = a_sx << 1;
            3'b100: begin
                mag = a_sx << 1;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = a_sx;
                neg = 1'b1;
            end
            default:        mag = '0;
        endcase
    end

    // Subtraction is invert-plus-carry on the already shifted term, so one adder serves both signs.
    assign term_sh = mag << shamt;
    assign addend  = neg ? ~term_sh : term_sh;
    assign acc_sum = acc_q + addend + {{(AW - 1){1'b0}}, neg};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: ;
            S_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d    = acc_sum[2*WIDTH-1:0];
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            a_d     = signed_mode ? {{2{op_a[WIDTH-1]}}, op_a} : {2'b00, op_a};
            b_d     = signed_mode ? {{2{op_b[WIDTH-1]}}, op_b} : {2'b00, op_b};
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench: directed corner cases on a 16-bit instance, randomized
// handshake traffic on 16-bit and 8-bit instances against an arithmetic reference.
module tb_booth_r4_seq_mult;

    logic        clk = 1'b0;
    logic        rst_v [2];
    logic        iv    [2];
    logic        sm    [2];
    logic        ordy  [2];
    logic [15:0] opa   [2];
    logic [15:0] opb   [2];

    logic        ir16, ov16, busy16;
    logic [31:0] res16;
    logic        ir8, ov8, busy8;
    logic [15:0] res8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst_v[0]), .in_valid(iv[0]), .in_ready(ir16),
        .op_a(opa[0]), .op_b(opb[0]), .signed_mode(sm[0]),
        .out_valid(ov16), .out_ready(ordy[0]), .result(res16), .busy(busy16)
    );

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst_v[1]), .in_valid(iv[1]), .in_ready(ir8),
        .op_a(opa[1][7:0]), .op_b(opb[1][7:0]), .signed_mode(sm[1]),
        .out_valid(ov8), .out_ready(ordy[1]), .result(res8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                             input bit s, input int w);
        longint sa, sb, mask1;
        mask1 = (longint'(1) << w) - 1;
        sa = longint'(a) & mask1;
        sb = longint'(b) & mask1;
        if (s && sa[w-1]) sa = sa - (longint'(1) << w);
        if (s && sb[w-1]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & ((64'(1) << (2 * w)) - 64'd1);
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return m;
            2:       return 16'(32'd1 << (w - 1));
            3:       return 16'((32'd1 << (w - 1)) - 1);
            default: return 16'($urandom) & m;
        endcase
    endfunction

    // Starts and ends one cycle phase after a rising edge, with the 16-bit block idle.
    task automatic mul16(input logic [15:0] a, input logic [15:0] b, input bit s,
                         input logic [31:0] exp, input string tag);
        int lat, bc;
        iv[0] = 1'b1; opa[0] = a; opb[0] = b; sm[0] = s; ordy[0] = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(ir16), 64'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0; bc = 0;
        while (!ov16 && lat < 40) begin
            if (busy16) bc++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd9);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd9);
        check({tag, "_result"}, 64'(res16), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_out_valid_drop"}, 64'(ov16), 64'd0);
    endtask

    task automatic wait_ov16(output int lat);
        lat = 0;
        while (!ov16 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic rand_run(input int d, input int w, input int n);
        logic [63:0] q[$];
        logic [63:0] exp;
        int done, cyc;
        bit  overlap;
        logic ir_s, ov_s, busy_s;
        logic [31:0] res_s;
        string tg;
        tg = (d == 0) ? "rand16" : "rand8";
        done = 0; cyc = 0; overlap = 0;
        while (done < n && cyc < 60000) begin
            @(posedge clk); #1;
            iv[d]   = ($urandom_range(0, 2) != 0);
            ordy[d] = ($urandom_range(0, 3) != 0);
            sm[d]   = 1'($urandom_range(0, 1));
            opa[d]  = pick(w);
            opb[d]  = pick(w);
            #1;
            ir_s   = (d == 0) ? ir16 : ir8;
            ov_s   = (d == 0) ? ov16 : ov8;
            busy_s = (d == 0) ? busy16 : busy8;
            res_s  = (d == 0) ? res16 : {16'd0, res8};
            if (busy_s && (ov_s || ir_s)) overlap = 1;
            if (iv[d] && ir_s) q.push_back(ref_prod(opa[d], opb[d], sm[d], w));
            if (ov_s && ordy[d]) begin
                if (q.size() == 0) begin
                    check({tg, "_unexpected_output"}, 64'(res_s), 64'hDEAD);
                end else begin
                    exp = q.pop_front();
                    check({tg, "_result"}, 64'(res_s), exp);
                end
                done++;
            end
            cyc++;
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        check({tg, "_completed"}, 64'(done), 64'(n));
        check({tg, "_busy_exclusive"}, 64'(overlap), 64'd0);
    endtask

    initial begin
        int lat, e1lat;
        bit stable;
        logic [31:0] snap;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; iv[i] = 1'b0; sm[i] = 1'b0; ordy[i] = 1'b1;
            opa[i] = '0; opb[i] = '0;
        end
        #13;
        check("reset_in_ready", 64'(ir16), 64'd1);
        check("reset_out_valid", 64'(ov16), 64'd0);
        check("reset_busy", 64'(busy16), 64'd0);
        check("reset_result", 64'(res16), 64'd0);
        @(negedge clk);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        @(posedge clk); #1;

        fork
            begin
                mul16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "min_x_min");
                mul16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "max_u");
                mul16(16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001, "m1_x_m1");
                mul16(16'hFFFF, 16'h0001, 1'b1, 32'hFFFF_FFFF, "m1_x_1");
                mul16(16'h7FFF, 16'h8000, 1'b1, 32'hC000_8000, "maxp_x_min");

                // Backpressure stall, then same-edge handoff and back-to-back issue.
                iv[0] = 1'b1; opa[0] = 16'h1234; opb[0] = 16'h5678; sm[0] = 1'b0; ordy[0] = 1'b0;
                @(posedge clk); #1;
                iv[0] = 1'b0;
                wait_ov16(lat);
                check("bp_latency", 64'(lat), 64'd9);
                snap = res16;
                check("bp_result", 64'(snap), ref_prod(16'h1234, 16'h5678, 1'b0, 16));
                stable = 1;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (res16 !== snap || ov16 !== 1'b1 || ir16 !== 1'b0) stable = 0;
                end
                check("bp_stall_stable", 64'(stable), 64'd1);
                iv[0] = 1'b1; opa[0] = 16'hFFFD; opb[0] = 16'h0007; sm[0] = 1'b1; ordy[0] = 1'b1;
                #1 check("handoff_in_ready", 64'(ir16), 64'd1);
                @(posedge clk); #1;
                check("handoff_out_valid", 64'(ov16), 64'd0);
                check("handoff_busy", 64'(busy16), 64'd1);
                opa[0] = 16'h8000; opb[0] = 16'h7FFF;
                wait_ov16(e1lat);
                check("handoff_latency", 64'(e1lat), 64'd9);
                check("handoff_result", 64'(res16), 64'hFFFF_FFEB);
                @(posedge clk); #1;
                check("b2b_busy", 64'(busy16), 64'd1);
                iv[0] = 1'b0;
                wait_ov16(lat);
                check("b2b_interval", 64'(e1lat + 1 + lat), 64'd19);
                check("b2b_result", 64'(res16), 64'hC000_8000);
                @(posedge clk); #1;

                // Asynchronous reset in the middle of a multiply.
                iv[0] = 1'b1; opa[0] = 16'h0123; opb[0] = 16'h0456; sm[0] = 1'b0;
                @(posedge clk); #1;
                iv[0] = 1'b0;
                repeat (4) @(posedge clk);
                #1 check("midrst_busy_before", 64'(busy16), 64'd1);
                rst_v[0] = 1'b1;
                #1;
                check("midrst_out_valid", 64'(ov16), 64'd0);
                check("midrst_result", 64'(res16), 64'd0);
                check("midrst_in_ready", 64'(ir16), 64'd1);
                check("midrst_busy", 64'(busy16), 64'd0);
                rst_v[0] = 1'b0;
                @(posedge clk); #1;
                mul16(16'd3, 16'd5, 1'b0, 32'd15, "after_rst");

                rand_run(0, 16, 2500);
            end
            rand_run(1, 8, 3000);
        join

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
